// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stage registers: state encoding, EX/MEM bundle layout, defaults.
// Latency: none (package only).
// Backpressure: not applicable.
package pipe_pkg;

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'b00,
        PIPE_FULL  = 2'b01,
        PIPE_SKID  = 2'b10
    } pipe_state_t;

    // EX/MEM field widths.
    localparam int INSTR_W        = 5;
    localparam int PC_W           = 32;
    localparam int ALU_RESULT_W   = 32;
    localparam int DATA2_W        = 32;
    localparam int IMMEDIATE_W    = 32;
    localparam int READ_WRITE_W   = 4;
    localparam int WB_SEL_W       = 2;
    localparam int DATAMEMSEL_W   = 1;
    localparam int REG_WRITE_EN_W = 1;

    // Data bundle layout: {DATA2, ALU_RESULT, PC}, LSB first.
    localparam int PC_OFF         = 0;
    localparam int ALU_RESULT_OFF = PC_OFF + PC_W;
    localparam int DATA2_OFF      = ALU_RESULT_OFF + ALU_RESULT_W;
    localparam int EXMEM_DATA_W   = DATA2_OFF + DATA2_W;

    // Control bundle layout: {spare, rd, READ_WRITE, WB_SEL, DATAMEMSEL, REG_WRITE_EN}, LSB first.
    localparam int REG_WRITE_EN_OFF = 0;
    localparam int DATAMEMSEL_OFF   = REG_WRITE_EN_OFF + REG_WRITE_EN_W;
    localparam int WB_SEL_OFF       = DATAMEMSEL_OFF + DATAMEMSEL_W;
    localparam int READ_WRITE_OFF   = WB_SEL_OFF + WB_SEL_W;
    localparam int INSTR_OFF        = READ_WRITE_OFF + READ_WRITE_W;
    localparam int EXMEM_CTRL_USED  = INSTR_OFF + INSTR_W;

    // Defaults for the stage register; the immediate travels in a widened data bundle when needed.
    localparam int DEF_DATA_WIDTH = EXMEM_DATA_W;
    localparam int DEF_CTRL_WIDTH = 16;
    localparam int DEF_CNT_WIDTH  = 16;
    localparam int DEF_IMM_DATA_WIDTH = EXMEM_DATA_W + IMMEDIATE_W;

endpackage

// File: rtl/pipe_reg_slot.sv
// One pipeline slot: enable-loaded data+control register, control can be cleared synchronously.
// Latency: 1 cycle from load to q.
// Backpressure: none; the owner decides when to load or clear.
module pipe_reg_slot #(
    parameter int DW = 96,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          clr_ctrl,
    input  logic [DW-1:0] d_data,
    input  logic [CW-1:0] d_ctrl,
    output logic [DW-1:0] q_data,
    output logic [CW-1:0] q_ctrl
);

    // Clearing control wins over load; data is kept on a clear so the bus does not toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_data <= '0;
            q_ctrl <= '0;
        end else if (clr_ctrl) begin
            q_ctrl <= '0;
        end else if (load) begin
            q_data <= d_data;
            q_ctrl <= d_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic_reg.sv
// Elastic pipeline stage register with 2-entry skid, BUSYWAIT stall and FLUSH; optional PIPE_STAGE_STALL_CNT_EN stall counter.
// Latency: 1 cycle accept-to-output when empty; full throughput while downstream drains.
// Backpressure: IN_READY is registered and drops only when the skid entry is occupied.
module pipe_stage_elastic_reg
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CTRL_WIDTH = DEF_CTRL_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    input  logic [CTRL_WIDTH-1:0] IN_CTRL,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic [CTRL_WIDTH-1:0] OUT_CTRL,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    input  logic                  BUSYWAIT,
    input  logic                  FLUSH,
    output logic [1:0]            OCCUPANCY,
    output logic [CNT_WIDTH-1:0]  STALL_COUNT
);

    pipe_state_t           state, state_nxt;
    logic                  in_ready_q;
    logic                  accept, drain;
    logic                  main_load, main_clr, main_from_skid;
    logic                  skid_load, skid_clr;
    logic [DATA_WIDTH-1:0] skid_data, main_d_data;
    logic [CTRL_WIDTH-1:0] skid_ctrl, main_d_ctrl;

    assign OUT_VALID = (state != PIPE_EMPTY);
    assign OCCUPANCY = state;
    assign IN_READY  = in_ready_q;
    assign accept    = IN_VALID & in_ready_q;
    assign drain     = OUT_VALID & OUT_READY & ~BUSYWAIT;

    // Next-state and slot-control decode; FLUSH overrides every other event.
    always_comb begin
        state_nxt      = state;
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (FLUSH) begin
            state_nxt = PIPE_EMPTY;
            main_clr  = 1'b1;
            skid_clr  = 1'b1;
        end else begin
            case (state)
                PIPE_EMPTY: begin
                    if (accept) begin
                        state_nxt = PIPE_FULL;
                        main_load = 1'b1;
                    end
                end
                PIPE_FULL: begin
                    if (accept && drain) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        state_nxt = PIPE_SKID;
                        skid_load = 1'b1;
                    end else if (drain) begin
                        state_nxt = PIPE_EMPTY;
                        main_clr  = 1'b1;
                    end
                end
                PIPE_SKID: begin
                    if (drain) begin
                        state_nxt      = PIPE_FULL;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                    end
                end
                default: begin
                    state_nxt = PIPE_EMPTY;
                    main_clr  = 1'b1;
                    skid_clr  = 1'b1;
                end
            endcase
        end
    end

    assign main_d_data = main_from_skid ? skid_data : IN_DATA;
    assign main_d_ctrl = main_from_skid ? skid_ctrl : IN_CTRL;

    // State register and registered ready: ready is withheld only while the skid is occupied.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= PIPE_EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != PIPE_SKID);
        end
    end

    pipe_reg_slot #(.DW(DATA_WIDTH), .CW(CTRL_WIDTH)) u_main (
        .clk      (CLK),
        .rst_n    (RESET),
        .load     (main_load),
        .clr_ctrl (main_clr),
        .d_data   (main_d_data),
        .d_ctrl   (main_d_ctrl),
        .q_data   (OUT_DATA),
        .q_ctrl   (OUT_CTRL)
    );

    pipe_reg_slot #(.DW(DATA_WIDTH), .CW(CTRL_WIDTH)) u_skid (
        .clk      (CLK),
        .rst_n    (RESET),
        .load     (skid_load),
        .clr_ctrl (skid_clr),
        .d_data   (IN_DATA),
        .d_ctrl   (IN_CTRL),
        .q_data   (skid_data),
        .q_ctrl   (skid_ctrl)
    );

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cnt;

    // Count cycles holding a valid entry that did not leave; saturates, survives FLUSH.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            stall_cnt <= '0;
        end else if (OUT_VALID && !drain && (stall_cnt != {CNT_WIDTH{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign STALL_COUNT = stall_cnt;
`else
    assign STALL_COUNT = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic_reg.sv
// Directed bench for pipe_stage_elastic_reg: reset, streaming, stall, flush, bubble, stall counter.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercised through OUT_READY and BUSYWAIT.
module tb_pipe_stage_elastic_reg;

    localparam int DW = 96;
    localparam int CW = 16;
    localparam int NW = 16;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic          busywait;
    logic          flush;
    logic [1:0]    occupancy;
    logic [NW-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    pipe_stage_elastic_reg #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)) dut (
        .CLK         (clk),
        .RESET       (rst_n),
        .IN_DATA     (in_data),
        .IN_CTRL     (in_ctrl),
        .IN_VALID    (in_valid),
        .IN_READY    (in_ready),
        .OUT_DATA    (out_data),
        .OUT_CTRL    (out_ctrl),
        .OUT_VALID   (out_valid),
        .OUT_READY   (out_ready),
        .BUSYWAIT    (busywait),
        .FLUSH       (flush),
        .OCCUPANCY   (occupancy),
        .STALL_COUNT (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic [CW-1:0] c);
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = c;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        busywait  = 1'b0;
        flush     = 1'b0;
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_stall", stall_count, 0);
        rst_n = 1'b1;
        tick();
        chk("rel_ready", in_ready, 1);

        // 1. reset mid-flow from SKID
        push(96'h14, 16'h0011);
        tick();
        push(96'h1E, 16'h0022);
        tick();
        in_valid = 1'b0;
        chk("t1_occ_skid", occupancy, 2);
        chk("t1_ready_skid", in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_async_valid", out_valid, 0);
        chk("t1_async_data", out_data, 0);
        chk("t1_async_ctrl", out_ctrl, 0);
        chk("t1_async_occ", occupancy, 0);
        chk("t1_async_ready", in_ready, 0);
        #2;
        rst_n = 1'b1;
        #1;
        chk("t1_rel_ready_pre", in_ready, 0);
        tick();
        chk("t1_rel_ready", in_ready, 1);
        chk("t1_rel_valid", out_valid, 0);

        // 2. streaming
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(96'h0A + DW'(i), 16'h0100 + CW'(i));
            tick();
            chk("t2_data", out_data, 96'h0A + DW'(i));
            chk("t2_ctrl", out_ctrl, 16'h0100 + CW'(i));
            chk("t2_occ", occupancy, 1);
            chk("t2_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        tick();
        chk("t2_empty_occ", occupancy, 0);
        chk("t2_empty_ctrl", out_ctrl, 0);
        chk("t2_empty_data", out_data, 96'h0C);

        // 3. BUSYWAIT stall
        busywait = 1'b1;
        push(96'h14, 16'h0A0A);
        tick();
        chk("t3_first", out_data, 96'h14);
        push(96'h46, 16'h0B0B);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("t3_hold_data", out_data, 96'h14);
            chk("t3_hold_ctrl", out_ctrl, 16'h0A0A);
            chk("t3_hold_occ", occupancy, 2);
            chk("t3_hold_ready", in_ready, 0);
            tick();
        end
        chk("t3_hold3_data", out_data, 96'h14);
        busywait = 1'b0;
        tick();
        chk("t3_second_data", out_data, 96'h46);
        chk("t3_second_ctrl", out_ctrl, 16'h0B0B);
        chk("t3_second_occ", occupancy, 1);
        chk("t3_second_ready", in_ready, 1);
        tick();
        chk("t3_drained_occ", occupancy, 0);
        chk("t3_drained_valid", out_valid, 0);

        // 4. FLUSH in SKID with IN_VALID high, then FLUSH in FULL with a real accept
        out_ready = 1'b0;
        push(96'h40, 16'h0001);
        tick();
        push(96'h41, 16'h0002);
        tick();
        chk("t4_pre_occ", occupancy, 2);
        push(96'h50, 16'h0050);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("t4_valid", out_valid, 0);
        chk("t4_ctrl", out_ctrl, 0);
        chk("t4_occ", occupancy, 0);
        chk("t4_ready", in_ready, 1);
        out_ready = 1'b1;
        tick();
        chk("t4_no50_valid", out_valid, 0);
        out_ready = 1'b0;
        push(96'h60, 16'h0060);
        tick();
        chk("t4_full_occ", occupancy, 1);
        push(96'h61, 16'h0061);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("t4b_occ", occupancy, 0);
        chk("t4b_valid", out_valid, 0);
        out_ready = 1'b1;
        tick();
        chk("t4b_no61_valid", out_valid, 0);
        // FLUSH while EMPTY
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4c_occ", occupancy, 0);
        chk("t4c_ready", in_ready, 1);

        // 5. bubble invariant
        push(96'h77, 16'hFFFF);
        tick();
        in_valid = 1'b0;
        chk("t5_ctrl_full", out_ctrl, 16'hFFFF);
        tick();
        chk("t5_valid", out_valid, 0);
        chk("t5_ctrl", out_ctrl, 16'h0000);
        chk("t5_data", out_data, 96'h77);

        // 6. stall counter
        apply_reset();
        out_ready = 1'b0;
        push(96'h99, 16'h0009);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
`ifdef PIPE_STAGE_STALL_CNT_EN
        chk("t6_count5", stall_count, 5);
        for (int i = 0; i < 65536 + 3; i++) tick();
        chk("t6_sat", stall_count, 16'hFFFF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t6_flush_keeps", stall_count, 16'hFFFF);
`else
        chk("t6_tied0", stall_count, 0);
`endif
        chk("t6_hold_data", out_data, 96'h99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog in case the stimulus stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
